l3_mshr_file: RTL and testbench

Miss Status Holding Register file for the L3 cache. It receives miss allocations from the L3 request handler and merges secondary misses to the same 64B line. It issues one line-fill read per primary miss to the memory-side AXI AR channel and tracks the refill beats. On the last beat it releases the entry and reports the fill, with its waiting-master mask, back to the request handler.

---
 rtl/l3_mshr_file.sv | 246 ++++++++++++++++++++++++
 tb/tb_l3_mshr_file.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/l3_mshr_file.sv
// L3 miss status holding register file: allocates/merges line misses,
// issues one AXI line-fill read per primary miss and retires entries on
// the last refill beat, reporting the waiting-master mask upstream.

module l3_mshr_entry #(
    parameter int LW          = 26,
    parameter int NUM_MASTERS = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_new,
    input  logic                   merge,
    input  logic [NUM_MASTERS-1:0] master_oh,
    input  logic [LW-1:0]          line_in,
    input  logic                   ar_fire,
    input  logic                   beat,
    input  logic                   beat_err,
    input  logic                   beat_last,
    output logic                   is_free,
    output logic                   is_pend,
    output logic                   is_inflight,
    output logic [LW-1:0]          line,
    output logic [NUM_MASTERS-1:0] mask,
    output logic [7:0]             cnt,
    output logic                   err
);
    typedef enum logic [1:0] {FREE, PEND, ISSUED, FILL} state_t;
    state_t state;

    assign is_free     = (state == FREE);
    assign is_pend     = (state == PEND);
    assign is_inflight = (state == ISSUED) || (state == FILL);

    // Entry lifecycle; the top only raises alloc_new on FREE, ar_fire on PEND
    // and beat on ISSUED/FILL, and never merges into an entry retiring this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FREE;
            line  <= '0;
            mask  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            if (alloc_new) begin
                state <= PEND;
                line  <= line_in;
                mask  <= master_oh;
                cnt   <= '0;
                err   <= 1'b0;
            end
            if (merge)
                mask <= mask | master_oh;
            if (ar_fire)
                state <= ISSUED;
            if (beat) begin
                if (beat_last) begin
                    state <= FREE;
                    mask  <= '0;
                    cnt   <= '0;
                    err   <= 1'b0;
                end else begin
                    state <= FILL;
                    cnt   <= (cnt == 8'hFF) ? cnt : cnt + 8'd1;
                    if (beat_err)
                        err <= 1'b1;
                end
            end
        end
    end
endmodule

module l3_mshr_file #(
    parameter int NUM_MSHR    = 32,
    parameter int NUM_MASTERS = 16,
    parameter int ADDR_WIDTH  = 32,
    parameter int LINE_OFFSET = 6,
    parameter int FILL_BEATS  = 16,
    localparam int IW = $clog2(NUM_MSHR),
    localparam int MW = $clog2(NUM_MASTERS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [ADDR_WIDTH-1:0]  alloc_addr,
    input  logic [MW-1:0]          alloc_master_id,
    output logic [IW-1:0]          alloc_id,
    output logic                   alloc_merged,
    output logic [NUM_MSHR-1:0]    mshr_avail,
    output logic                   mshr_full,
    output logic                   mem_ar_valid,
    input  logic                   mem_ar_ready,
    output logic [ADDR_WIDTH-1:0]  mem_ar_addr,
    output logic [IW-1:0]          mem_ar_id,
    output logic [7:0]             mem_ar_len,
    input  logic                   mem_r_valid,
    output logic                   mem_r_ready,
    input  logic [IW-1:0]          mem_r_id,
    input  logic [1:0]             mem_r_resp,
    input  logic                   mem_r_last,
    output logic                   fill_done_valid,
    input  logic                   fill_done_ready,
    output logic [IW-1:0]          fill_done_id,
    output logic [ADDR_WIDTH-1:0]  fill_done_addr,
    output logic [NUM_MASTERS-1:0] fill_done_masters,
    output logic                   fill_done_err,
    output logic                   err_spurious,
    output logic [31:0]            alloc_count,
    output logic [31:0]            merge_count
);
    localparam int LW = ADDR_WIDTH - LINE_OFFSET;

    logic [NUM_MSHR-1:0]                  e_free, e_pend, e_infl, e_err;
    logic [NUM_MSHR-1:0]                  e_alloc, e_merge, e_arf, e_beat;
    logic [NUM_MSHR-1:0][LW-1:0]          e_line;
    logic [NUM_MSHR-1:0][NUM_MASTERS-1:0] e_mask;
    logic [NUM_MSHR-1:0][7:0]             e_cnt;

    logic [LW-1:0]          alloc_line;
    logic [NUM_MASTERS-1:0] master_oh;
    logic                   any_match, any_free, any_pend;
    logic [IW-1:0]          match_idx, free_idx, pend_idx;
    logic                   a_fire, ar_fire, r_fire, r_ok, r_retire;
    logic [8:0]             beats_seen;

    assign alloc_line = alloc_addr[ADDR_WIDTH-1:LINE_OFFSET];
    assign master_oh  = NUM_MASTERS'(1) << alloc_master_id;

    assign mem_r_ready = !fill_done_valid || fill_done_ready;
    assign r_fire      = mem_r_valid && mem_r_ready;
    assign r_ok        = r_fire && e_infl[mem_r_id];
    assign r_retire    = r_ok && mem_r_last;
    assign ar_fire     = mem_ar_valid && mem_ar_ready;
    assign beats_seen  = {1'b0, e_cnt[mem_r_id]} + 9'd1;

    // Line match (skipping an entry retiring this cycle) and lowest-index free/pending pick.
    always_comb begin
        any_match = 1'b0;
        match_idx = '0;
        any_free  = 1'b0;
        free_idx  = '0;
        any_pend  = 1'b0;
        pend_idx  = '0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!e_free[i] && (e_line[i] == alloc_line) &&
                !(r_retire && (mem_r_id == IW'(i)))) begin
                any_match = 1'b1;
                match_idx = IW'(i);
            end
            if (e_free[i]) begin
                any_free = 1'b1;
                free_idx = IW'(i);
            end
            if (e_pend[i]) begin
                any_pend = 1'b1;
                pend_idx = IW'(i);
            end
        end
    end

    assign mshr_avail   = e_free;
    assign mshr_full    = !any_free;
    assign alloc_ready  = any_match || !mshr_full;
    assign alloc_id     = any_match ? match_idx : free_idx;
    assign alloc_merged = any_match;
    assign a_fire       = alloc_valid && alloc_ready;
    assign mem_ar_len   = 8'(FILL_BEATS - 1);

    for (genvar g = 0; g < NUM_MSHR; g++) begin : g_ent
        assign e_alloc[g] = a_fire && !any_match && (free_idx == IW'(g));
        assign e_merge[g] = a_fire && any_match && (match_idx == IW'(g));
        assign e_arf[g]   = ar_fire && (mem_ar_id == IW'(g));
        assign e_beat[g]  = r_ok && (mem_r_id == IW'(g));

        l3_mshr_entry #(.LW(LW), .NUM_MASTERS(NUM_MASTERS)) u_ent (
            .clk         (clk),
            .rst         (rst),
            .alloc_new   (e_alloc[g]),
            .merge       (e_merge[g]),
            .master_oh   (master_oh),
            .line_in     (alloc_line),
            .ar_fire     (e_arf[g]),
            .beat        (e_beat[g]),
            .beat_err    (mem_r_resp != 2'b00),
            .beat_last   (mem_r_last),
            .is_free     (e_free[g]),
            .is_pend     (e_pend[g]),
            .is_inflight (e_infl[g]),
            .line        (e_line[g]),
            .mask        (e_mask[g]),
            .cnt         (e_cnt[g]),
            .err         (e_err[g])
        );
    end

    // AR issue: launch the lowest pending entry, hold until accepted, then idle one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ar_valid <= 1'b0;
            mem_ar_id    <= '0;
            mem_ar_addr  <= '0;
        end else if (ar_fire) begin
            mem_ar_valid <= 1'b0;
        end else if (!mem_ar_valid && any_pend) begin
            mem_ar_valid <= 1'b1;
            mem_ar_id    <= pend_idx;
            mem_ar_addr  <= {e_line[pend_idx], {LINE_OFFSET{1'b0}}};
        end
    end

    // One-deep completion slot; a retiring beat may reload it as the old one drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            fill_done_valid   <= 1'b0;
            fill_done_id      <= '0;
            fill_done_addr    <= '0;
            fill_done_masters <= '0;
            fill_done_err     <= 1'b0;
        end else if (r_retire) begin
            fill_done_valid   <= 1'b1;
            fill_done_id      <= mem_r_id;
            fill_done_addr    <= {e_line[mem_r_id], {LINE_OFFSET{1'b0}}};
            fill_done_masters <= e_mask[mem_r_id];
            fill_done_err     <= e_err[mem_r_id] || (mem_r_resp != 2'b00) ||
                                 (beats_seen != 9'(FILL_BEATS));
        end else if (fill_done_valid && fill_done_ready) begin
            fill_done_valid   <= 1'b0;
        end
    end

    // Statistics and the sticky stray-beat flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            alloc_count  <= '0;
            merge_count  <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (a_fire && !any_match)
                alloc_count <= alloc_count + 32'd1;
            if (a_fire && any_match)
                merge_count <= merge_count + 32'd1;
            if (r_fire && !e_infl[mem_r_id])
                err_spurious <= 1'b1;
        end
    end
endmodule

// File: tb/tb_l3_mshr_file.sv
// Directed bench for l3_mshr_file: single fill, merging, full/reuse,
// completion back-pressure, error reporting and retire/alloc collision.

module tb_l3_mshr_file;
    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [31:0] alloc_addr;
    logic [3:0]  alloc_master_id;
    logic [4:0]  alloc_id;
    logic        alloc_merged;
    logic [31:0] mshr_avail;
    logic        mshr_full;
    logic        mem_ar_valid;
    logic        mem_ar_ready;
    logic [31:0] mem_ar_addr;
    logic [4:0]  mem_ar_id;
    logic [7:0]  mem_ar_len;
    logic        mem_r_valid;
    logic        mem_r_ready;
    logic [4:0]  mem_r_id;
    logic [1:0]  mem_r_resp;
    logic        mem_r_last;
    logic        fill_done_valid;
    logic        fill_done_ready;
    logic [4:0]  fill_done_id;
    logic [31:0] fill_done_addr;
    logic [15:0] fill_done_masters;
    logic        fill_done_err;
    logic        err_spurious;
    logic [31:0] alloc_count;
    logic [31:0] merge_count;

    int checks = 0;
    int fails  = 0;

    l3_mshr_file dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_addr(alloc_addr),
        .alloc_master_id(alloc_master_id), .alloc_id(alloc_id), .alloc_merged(alloc_merged),
        .mshr_avail(mshr_avail), .mshr_full(mshr_full),
        .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
        .mem_ar_id(mem_ar_id), .mem_ar_len(mem_ar_len),
        .mem_r_valid(mem_r_valid), .mem_r_ready(mem_r_ready), .mem_r_id(mem_r_id),
        .mem_r_resp(mem_r_resp), .mem_r_last(mem_r_last),
        .fill_done_valid(fill_done_valid), .fill_done_ready(fill_done_ready),
        .fill_done_id(fill_done_id), .fill_done_addr(fill_done_addr),
        .fill_done_masters(fill_done_masters), .fill_done_err(fill_done_err),
        .err_spurious(err_spurious), .alloc_count(alloc_count), .merge_count(merge_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        alloc_valid = 0; alloc_addr = '0; alloc_master_id = '0;
        mem_ar_ready = 0; mem_r_valid = 0; mem_r_id = '0; mem_r_resp = '0; mem_r_last = 0;
        fill_done_ready = 0;
        tick;
        tick;
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic [31:0] a, input int m, output logic [4:0] id, output logic mg);
        int n = 0;
        alloc_valid = 1; alloc_addr = a; alloc_master_id = 4'(m);
        #1;
        while (!alloc_ready && n < 50) begin @(posedge clk); #2; n++; end
        checks++;
        if (!alloc_ready) begin
            fails++;
            $display("FAIL alloc_timeout: alloc_ready=%0b for addr %h, expected 1", alloc_ready, a);
        end
        id = alloc_id; mg = alloc_merged;
        tick;
        alloc_valid = 0;
    endtask

    task automatic issue_ar(output logic [4:0] id, output logic [31:0] a);
        int n = 0;
        while (!mem_ar_valid && n < 20) begin tick; n++; end
        checks++;
        if (!mem_ar_valid) begin
            fails++;
            $display("FAIL ar_timeout: mem_ar_valid=%0b after %0d cycles, expected 1", mem_ar_valid, n);
        end
        id = mem_ar_id; a = mem_ar_addr;
        mem_ar_ready = 1;
        tick;
        mem_ar_ready = 0;
    endtask

    task automatic send_beat(input logic [4:0] id, input logic [1:0] resp, input logic last);
        int n = 0;
        mem_r_valid = 1; mem_r_id = id; mem_r_resp = resp; mem_r_last = last;
        #1;
        while (!mem_r_ready && n < 50) begin @(posedge clk); #2; n++; end
        checks++;
        if (!mem_r_ready) begin
            fails++;
            $display("FAIL beat_timeout: mem_r_ready=%0b for id %0d, expected 1", mem_r_ready, id);
        end
        tick;
        mem_r_valid = 0; mem_r_last = 0; mem_r_resp = 0;
    endtask

    task automatic send_fill(input logic [4:0] id, input int nb, input int bad, input logic with_last);
        for (int b = 0; b < nb; b++)
            send_beat(id, (b == bad) ? 2'b10 : 2'b00, with_last && (b == nb - 1));
    endtask

    task automatic take_fill(output logic [4:0] id, output logic [31:0] a,
                             output logic [15:0] m, output logic e);
        int n = 0;
        while (!fill_done_valid && n < 50) begin tick; n++; end
        checks++;
        if (!fill_done_valid) begin
            fails++;
            $display("FAIL fill_timeout: fill_done_valid=%0b after %0d cycles, expected 1", fill_done_valid, n);
        end
        id = fill_done_id; a = fill_done_addr; m = fill_done_masters; e = fill_done_err;
        fill_done_ready = 1;
        tick;
        fill_done_ready = 0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++; if (mem_ar_valid !== 1'b0) begin fails++; $display("FAIL rst_ar_valid: got %b want 0", mem_ar_valid); end
        checks++; if (fill_done_valid !== 1'b0) begin fails++; $display("FAIL rst_fd_valid: got %b want 0", fill_done_valid); end
        checks++; if (err_spurious !== 1'b0) begin fails++; $display("FAIL rst_err_spurious: got %b want 0", err_spurious); end
        checks++; if (alloc_count !== 32'd0 || merge_count !== 32'd0) begin fails++; $display("FAIL rst_counts: got %0d/%0d want 0/0", alloc_count, merge_count); end
        checks++; if (mshr_avail !== 32'hFFFF_FFFF) begin fails++; $display("FAIL rst_avail: got %h want ffffffff", mshr_avail); end
        checks++; if (mshr_full !== 1'b0 || alloc_ready !== 1'b1) begin fails++; $display("FAIL rst_full_ready: got full=%b ready=%b want 0/1", mshr_full, alloc_ready); end
        checks++; if (mem_r_ready !== 1'b1) begin fails++; $display("FAIL rst_r_ready: got %b want 1", mem_r_ready); end
    endtask

    task automatic test_single_fill;
        logic [4:0] id, fid; logic mg, e; logic [31:0] a; logic [15:0] m;
        do_reset;
        alloc(32'h1000, 3, id, mg);
        checks++; if (id !== 5'd0 || mg !== 1'b0) begin fails++; $display("FAIL single_alloc: got id=%0d merged=%b want 0/0", id, mg); end
        checks++; if (mshr_avail !== 32'hFFFF_FFFE) begin fails++; $display("FAIL single_avail: got %h want fffffffe", mshr_avail); end
        checks++; if (mem_ar_len !== 8'd15) begin fails++; $display("FAIL single_ar_len: got %0d want 15", mem_ar_len); end
        issue_ar(id, a);
        checks++; if (id !== 5'd0 || a !== 32'h1000) begin fails++; $display("FAIL single_ar: got id=%0d addr=%h want 0/00001000", id, a); end
        checks++; if (mem_ar_valid !== 1'b0) begin fails++; $display("FAIL single_ar_drop: got %b want 0", mem_ar_valid); end
        send_fill(5'd0, 16, -1, 1'b1);
        checks++; if (mshr_avail !== 32'hFFFF_FFFF) begin fails++; $display("FAIL single_avail_free: got %h want ffffffff", mshr_avail); end
        take_fill(fid, a, m, e);
        checks++; if (fid !== 5'd0 || a !== 32'h1000 || m !== 16'h0008 || e !== 1'b0) begin
            fails++; $display("FAIL single_fill: got id=%0d addr=%h masters=%h err=%b want 0/00001000/0008/0", fid, a, m, e); end
        checks++; if (fill_done_valid !== 1'b0) begin fails++; $display("FAIL single_fd_drain: got %b want 0", fill_done_valid); end
        checks++; if (alloc_count !== 32'd1) begin fails++; $display("FAIL single_alloc_count: got %0d want 1", alloc_count); end
    endtask

    task automatic test_merge;
        logic [4:0] id, fid; logic mg, e, seen; logic [31:0] a; logic [15:0] m;
        do_reset;
        alloc(32'h2040, 1, id, mg);
        checks++; if (id !== 5'd0 || mg !== 1'b0) begin fails++; $display("FAIL merge_first: got id=%0d merged=%b want 0/0", id, mg); end
        alloc(32'h207C, 5, id, mg);
        checks++; if (id !== 5'd0 || mg !== 1'b1) begin fails++; $display("FAIL merge_second: got id=%0d merged=%b want 0/1", id, mg); end
        issue_ar(id, a);
        checks++; if (a !== 32'h2040) begin fails++; $display("FAIL merge_ar_addr: got %h want 00002040", a); end
        seen = 0;
        for (int i = 0; i < 6; i++) begin if (mem_ar_valid) seen = 1; tick; end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL merge_one_ar: extra AR seen=%b want 0", seen); end
        send_fill(5'd0, 16, -1, 1'b1);
        take_fill(fid, a, m, e);
        checks++; if (m !== 16'h0022 || e !== 1'b0) begin fails++; $display("FAIL merge_masters: got %h err=%b want 0022/0", m, e); end
        checks++; if (merge_count !== 32'd1 || alloc_count !== 32'd1) begin fails++; $display("FAIL merge_counts: got merge=%0d alloc=%0d want 1/1", merge_count, alloc_count); end
    endtask

    task automatic test_full;
        logic [4:0] id, fid; logic mg, e; logic [31:0] a; logic [15:0] m; int bad;
        do_reset;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            alloc(32'h10000 + 32'(i * 64), i % 16, id, mg);
            if (id !== 5'(i) || mg !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin fails++; $display("FAIL full_ids: %0d allocations got wrong id/merged, want 0", bad); end
        checks++; if (mshr_full !== 1'b1 || mshr_avail !== 32'h0) begin fails++; $display("FAIL full_flag: got full=%b avail=%h want 1/00000000", mshr_full, mshr_avail); end
        alloc_valid = 1; alloc_addr = 32'h20000; alloc_master_id = 4'd2;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_hold: got ready=%b want 0", alloc_ready); end
        issue_ar(id, a);
        checks++; if (id !== 5'd0) begin fails++; $display("FAIL full_ar_id: got %0d want 0", id); end
        send_fill(5'd0, 15, -1, 1'b0);
        mem_r_valid = 1; mem_r_id = 5'd0; mem_r_resp = 0; mem_r_last = 1;
        #1;
        checks++; if (alloc_ready !== 1'b0) begin fails++; $display("FAIL full_same_cycle: got ready=%b want 0", alloc_ready); end
        tick;
        mem_r_valid = 0; mem_r_last = 0;
        #1;
        checks++; if (alloc_ready !== 1'b1 || alloc_id !== 5'd0 || alloc_merged !== 1'b0) begin
            fails++; $display("FAIL full_reuse: got ready=%b id=%0d merged=%b want 1/0/0", alloc_ready, alloc_id, alloc_merged); end
        tick;
        alloc_valid = 0;
        checks++; if (mshr_full !== 1'b1 || alloc_count !== 32'd33) begin fails++; $display("FAIL full_after: got full=%b count=%0d want 1/33", mshr_full, alloc_count); end
        take_fill(fid, a, m, e);
        checks++; if (fid !== 5'd0 || m !== 16'h0001 || e !== 1'b0) begin fails++; $display("FAIL full_fill: got id=%0d masters=%h err=%b want 0/0001/0", fid, m, e); end
        checks++; if (mem_ar_valid !== 1'b1) begin fails++; $display("FAIL full_ar_pending: got %b want 1", mem_ar_valid); end
        do_reset;
        checks++; if (mshr_avail !== 32'hFFFF_FFFF || mem_ar_valid !== 1'b0 || alloc_count !== 32'd0) begin
            fails++; $display("FAIL midop_reset: got avail=%h ar_valid=%b count=%0d want ffffffff/0/0", mshr_avail, mem_ar_valid, alloc_count); end
    endtask

    task automatic test_backpressure;
        logic [4:0] id; logic mg; logic [31:0] a;
        do_reset;
        alloc(32'h3000, 0, id, mg);
        alloc(32'h3040, 1, id, mg);
        issue_ar(id, a);
        issue_ar(id, a);
        checks++; if (id !== 5'd1 || a !== 32'h3040) begin fails++; $display("FAIL bp_second_ar: got id=%0d addr=%h want 1/00003040", id, a); end
        send_fill(5'd1, 15, -1, 1'b0);
        send_fill(5'd0, 16, -1, 1'b1);
        mem_r_valid = 1; mem_r_id = 5'd1; mem_r_resp = 0; mem_r_last = 1;
        #1;
        checks++; if (mem_r_ready !== 1'b0) begin fails++; $display("FAIL bp_r_ready: got %b want 0", mem_r_ready); end
        tick;
        tick;
        checks++; if (fill_done_valid !== 1'b1 || fill_done_id !== 5'd0 || fill_done_masters !== 16'h0001) begin
            fails++; $display("FAIL bp_hold: got valid=%b id=%0d masters=%h want 1/0/0001", fill_done_valid, fill_done_id, fill_done_masters); end
        fill_done_ready = 1;
        #1;
        checks++; if (mem_r_ready !== 1'b1) begin fails++; $display("FAIL bp_release: got r_ready=%b want 1", mem_r_ready); end
        tick;
        mem_r_valid = 0; mem_r_last = 0;
        checks++; if (fill_done_valid !== 1'b1 || fill_done_id !== 5'd1 || fill_done_masters !== 16'h0002 || fill_done_err !== 1'b0) begin
            fails++; $display("FAIL bp_next: got valid=%b id=%0d masters=%h err=%b want 1/1/0002/0", fill_done_valid, fill_done_id, fill_done_masters, fill_done_err); end
        tick;
        fill_done_ready = 0;
        checks++; if (fill_done_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b want 0", fill_done_valid); end
    endtask

    task automatic test_errors;
        logic [4:0] id, fid; logic mg, e; logic [31:0] a; logic [15:0] m;
        do_reset;
        send_beat(5'd7, 2'b00, 1'b0);
        checks++; if (err_spurious !== 1'b1 || fill_done_valid !== 1'b0 || mshr_avail !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL spurious_set: got err=%b fd_valid=%b avail=%h want 1/0/ffffffff", err_spurious, fill_done_valid, mshr_avail); end
        tick; tick;
        checks++; if (err_spurious !== 1'b1) begin fails++; $display("FAIL spurious_sticky: got %b want 1", err_spurious); end
        alloc(32'h4000, 2, id, mg);
        alloc(32'h4040, 4, id, mg);
        issue_ar(id, a);
        issue_ar(id, a);
        send_fill(5'd0, 15, -1, 1'b1);
        take_fill(fid, a, m, e);
        checks++; if (fid !== 5'd0 || m !== 16'h0004 || e !== 1'b1) begin fails++; $display("FAIL short_fill_err: got id=%0d masters=%h err=%b want 0/0004/1", fid, m, e); end
        send_fill(5'd1, 16, 5, 1'b1);
        take_fill(fid, a, m, e);
        checks++; if (fid !== 5'd1 || a !== 32'h4040 || m !== 16'h0010 || e !== 1'b1) begin
            fails++; $display("FAIL slverr_fill: got id=%0d addr=%h masters=%h err=%b want 1/00004040/0010/1", fid, a, m, e); end
    endtask

    task automatic test_retire_alloc_collision;
        logic [4:0] id, fid; logic mg, e; logic [31:0] a; logic [15:0] m;
        do_reset;
        alloc(32'h5000, 6, id, mg);
        issue_ar(id, a);
        send_fill(5'd0, 15, -1, 1'b0);
        mem_r_valid = 1; mem_r_id = 5'd0; mem_r_resp = 0; mem_r_last = 1;
        alloc_valid = 1; alloc_addr = 32'h5010; alloc_master_id = 4'd9;
        #1;
        checks++; if (alloc_ready !== 1'b1 || alloc_merged !== 1'b0 || alloc_id !== 5'd1) begin
            fails++; $display("FAIL collide_alloc: got ready=%b merged=%b id=%0d want 1/0/1", alloc_ready, alloc_merged, alloc_id); end
        tick;
        mem_r_valid = 0; mem_r_last = 0; alloc_valid = 0;
        checks++; if (mshr_avail !== 32'hFFFF_FFFD || alloc_count !== 32'd2 || merge_count !== 32'd0) begin
            fails++; $display("FAIL collide_state: got avail=%h alloc=%0d merge=%0d want fffffffd/2/0", mshr_avail, alloc_count, merge_count); end
        take_fill(fid, a, m, e);
        checks++; if (fid !== 5'd0 || m !== 16'h0040 || e !== 1'b0) begin fails++; $display("FAIL collide_fill: got id=%0d masters=%h err=%b want 0/0040/0", fid, m, e); end
        issue_ar(id, a);
        checks++; if (id !== 5'd1 || a !== 32'h5000) begin fails++; $display("FAIL collide_second_ar: got id=%0d addr=%h want 1/00005000", id, a); end
    endtask

    initial begin
        test_reset;
        test_single_fill;
        test_merge;
        test_full;
        test_backpressure;
        test_errors;
        test_retire_alloc_collision;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end
endmodule
